// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, FSM states and op decode helpers for muldiv_unit
//
// Purpose : common types for the multiply/divide unit and its divider core.
// Contents: op_e    - operation encoding driven on muldiv_unit.op
//           state_e - control FSM states of muldiv_unit
//           op_is_div / op_is_signed - decode helpers used by both modules
package muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10,
      ST_FIX  = 2'b11
   } state_e;

   // op[1] selects the divider, op[0] selects unsigned arithmetic
   function automatic logic op_is_div(input op_e o);
      return o[1];
   endfunction

   function automatic logic op_is_signed(input op_e o);
      return ~o[0];
   endfunction

endpackage

// File: rtl/muldiv_divcore.sv
// rtl/muldiv_divcore.sv - iterative radix-2 restoring divider with sign fix-up
//
// Purpose : computes quotient/remainder one bit per step on magnitudes,
//           then restores signs combinationally (quotient truncates toward
//           zero, remainder follows the dividend).
// Ports   : clk, rst       - clock, asynchronous active-low reset
//           load           - capture dividend/divisor/op and clear the counter
//           step           - perform one quotient-bit iteration
//           op             - operation (only signedness is used here)
//           dividend       - numerator, sampled on load
//           divisor        - denominator, sampled on load (must be non-zero)
//           last           - high during the step that produces the final bit
//           quotient       - sign-corrected quotient
//           remainder      - sign-corrected remainder
module muldiv_divcore
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  op_e              op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             last,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] dvs_q;
   logic             neg_quo;
   logic             neg_rem;
   logic [CW-1:0]    cnt;

   logic             sgn;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;

   assign sgn   = op_is_signed(op);
   // The most negative dividend maps to 2^(WIDTH-1) as an unsigned magnitude,
   // which lets MIN / -1 fall out as quotient MIN, remainder 0 after the fix-up.
   assign abs_a = (sgn && dividend[WIDTH-1]) ? -dividend : dividend;
   assign abs_b = (sgn && divisor[WIDTH-1])  ? -divisor  : divisor;

   // quo_q doubles as the dividend shift register: its MSB feeds the
   // partial remainder while quotient bits enter from the LSB.
   assign shifted = {rem_q, quo_q[WIDTH-1]};
   assign diff    = shifted - {1'b0, dvs_q};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         neg_quo <= 1'b0;
         neg_rem <= 1'b0;
         cnt     <= '0;
      end else if (load) begin
         rem_q   <= '0;
         quo_q   <= abs_a;
         dvs_q   <= abs_b;
         neg_quo <= sgn & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
         neg_rem <= sgn & dividend[WIDTH-1];
         cnt     <= '0;
      end else if (step) begin
         if (!diff[WIDTH]) begin
            rem_q <= diff[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
         end else begin
            rem_q <= shifted[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
         end
         cnt <= cnt + 1'b1;
      end
   end

   assign last      = step && (cnt == LAST_CNT);
   assign quotient  = neg_quo ? -quo_q : quo_q;
   assign remainder = neg_rem ? -rem_q : rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - HI/LO multiply/divide unit with fixed-latency multiply and iterative divide
//
// Purpose : executes MULT/MULTU/DIV/DIVU into the architectural HI/LO pair,
//           supports direct MTHI/MTLO writes and pipeline annul.
// Ports   : clk, rst        - clock, asynchronous active-low reset
//           start, op, a, b - operation request, sampled while not busy
//           annul           - cancel any in-flight operation
//           hi_we, lo_we    - direct write of wdata into HI / LO
//           wdata           - direct-write data
//           busy            - operation in flight
//           done            - one-cycle pulse when a result commits
//           dbz             - qualifies done: divide with zero divisor
//           hi, lo          - architectural HI / LO registers
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MUL_LATENCY = 2
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             annul,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             dbz,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [1:0] MUL_LAST = 2'(MUL_LATENCY - 1);

   state_e             state;
   op_e                op_in;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic               mul_signed;
   logic               dbz_pend;
   logic [1:0]         mul_cnt;

   logic [2*WIDTH-1:0] ext_a;
   logic [2*WIDTH-1:0] ext_b;
   logic [2*WIDTH-1:0] product;

   logic               div_load;
   logic               div_step;
   logic               div_last;
   logic [WIDTH-1:0]   div_quo;
   logic [WIDTH-1:0]   div_rem;

   assign op_in = op_e'(op);

   // Sign- or zero-extend to double width; the low 2*WIDTH bits of the
   // modular product are then the correct signed or unsigned result.
   assign ext_a   = {{WIDTH{mul_signed & a_q[WIDTH-1]}}, a_q};
   assign ext_b   = {{WIDTH{mul_signed & b_q[WIDTH-1]}}, b_q};
   assign product = ext_a * ext_b;

   assign div_load = (state == ST_IDLE) && start && !annul && op_is_div(op_in);
   assign div_step = (state == ST_DIV);

   muldiv_divcore #(
      .WIDTH (WIDTH)
   ) u_divcore (
      .clk       (clk),
      .rst       (rst),
      .load      (div_load),
      .step      (div_step),
      .op        (op_in),
      .dividend  (a),
      .divisor   (b),
      .last      (div_last),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         dbz        <= 1'b0;
         hi         <= '0;
         lo         <= '0;
         a_q        <= '0;
         b_q        <= '0;
         mul_signed <= 1'b0;
         dbz_pend   <= 1'b0;
         mul_cnt    <= '0;
      end else begin
         done <= 1'b0;
         dbz  <= 1'b0;

         // Direct writes go first so a same-edge result commit below overrides them.
         if (hi_we) hi <= wdata;
         if (lo_we) lo <= wdata;

         if (annul) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start) begin
                     a_q        <= a;
                     b_q        <= b;
                     mul_signed <= op_is_signed(op_in);
                     mul_cnt    <= '0;
                     busy       <= 1'b1;
                     if (!op_is_div(op_in)) begin
                        state <= ST_MUL;
                     end else if (b == '0) begin
                        // Zero divisor: bypass the iterations, report through FIX.
                        dbz_pend <= 1'b1;
                        state    <= ST_FIX;
                     end else begin
                        dbz_pend <= 1'b0;
                        state    <= ST_DIV;
                     end
                  end
               end
               ST_MUL: begin
                  if (mul_cnt == MUL_LAST) begin
                     hi    <= product[2*WIDTH-1:WIDTH];
                     lo    <= product[WIDTH-1:0];
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= ST_IDLE;
                  end else begin
                     mul_cnt <= mul_cnt + 2'd1;
                  end
               end
               ST_DIV: begin
                  if (div_last) state <= ST_FIX;
               end
               ST_FIX: begin
                  if (!dbz_pend) begin
                     hi <= div_rem;
                     lo <= div_quo;
                  end
                  done  <= 1'b1;
                  dbz   <= dbz_pend;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
               default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit with directed and random operations
module tb_muldiv_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        annul;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        dbz;
   logic [31:0] hi;
   logic [31:0] lo;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   muldiv_unit #(
      .WIDTH       (32),
      .MUL_LATENCY (2)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .annul (annul),
      .hi_we (hi_we),
      .lo_we (lo_we),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .dbz   (dbz),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Architectural result of one operation, from plain integer arithmetic.
   task automatic model_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                           output logic d);
      longint      sx;
      longint      sy;
      longint      q;
      longint      r;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      d  = 1'b0;
      case (o)
         2'b00: begin p = sx * sy; m_hi = p[63:32]; m_lo = p[31:0]; end
         2'b01: begin p = {32'd0, x} * {32'd0, y}; m_hi = p[63:32]; m_lo = p[31:0]; end
         2'b10: begin
            if (y == 32'd0) d = 1'b1;
            else begin q = sx / sy; r = sx % sy; m_lo = q[31:0]; m_hi = r[31:0]; end
         end
         default: begin
            if (y == 32'd0) d = 1'b1;
            else begin m_lo = x / y; m_hi = x % y; end
         end
      endcase
   endtask

   // Issue one operation at the current negedge and follow it to done.
   // wr_at: sample index at which hi_we is driven (-1 none);
   // restart_at: sample index at which a spurious start is driven (-1 none).
   task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int wr_at, input int restart_at);
      int   n;
      int   busy_n;
      int   exp_lat;
      logic exp_dbz;
      exp_lat = o[1] ? ((y == 32'd0) ? 1 : 33) : 2;
      if (wr_at >= 0 && wr_at < exp_lat) m_hi = 32'h12345678;
      model_op(o, x, y, exp_dbz);
      start = 1'b1; op = o; a = x; b = y;
      wdata = 32'h12345678;
      @(negedge clk);
      start  = 1'b0;
      n      = 0;
      busy_n = 0;
      while (done !== 1'b1 && n < 100) begin
         if (busy === 1'b1) busy_n++;
         if (wr_at >= 0 && n == wr_at + 1) check({tag, "_hi_direct"}, hi, 32'h12345678);
         hi_we = (wr_at >= 0 && n == wr_at);
         if (n == restart_at) begin
            start = 1'b1; op = 2'b00; a = $urandom; b = $urandom;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      hi_we = 1'b0;
      start = 1'b0;
      check({tag, "_latency"}, n, exp_lat);
      check({tag, "_busy_cycles"}, busy_n, exp_lat);
      check({tag, "_busy_at_done"}, busy, 1'b0);
      check({tag, "_dbz"}, dbz, exp_dbz);
      check({tag, "_hi"}, hi, m_hi);
      check({tag, "_lo"}, lo, m_lo);
   endtask

   task automatic watch_no_done(input string tag, input int cycles);
      int cnt;
      cnt = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (done === 1'b1) cnt++;
      end
      check({tag, "_no_done"}, cnt, 0);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
      annul = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;

      #3;
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_dbz", dbz, 1'b0);
      @(negedge clk);
      rst = 1'b1;

      // Multiply signed / unsigned
      do_op("mult", 2'b00, 32'hFFFFFFFE, 32'd3, -1, -1);
      check("mult_hi_const", hi, 32'hFFFFFFFF);
      check("mult_lo_const", lo, 32'hFFFFFFFA);
      do_op("multu", 2'b01, 32'hFFFFFFFE, 32'd3, -1, -1);
      check("multu_hi_const", hi, 32'h00000002);
      check("multu_lo_const", lo, 32'hFFFFFFFA);

      // Divide signed / unsigned, issued back-to-back from the done cycle
      do_op("div", 2'b10, 32'hFFFFFFF9, 32'd2, -1, -1);
      check("div_lo_const", lo, 32'hFFFFFFFD);
      check("div_hi_const", hi, 32'hFFFFFFFF);
      do_op("divu", 2'b11, 32'd7, 32'd2, -1, -1);
      check("divu_lo_const", lo, 32'd3);
      check("divu_hi_const", hi, 32'd1);

      // Overflow case and divide by zero
      do_op("div_min", 2'b10, 32'h80000000, 32'hFFFFFFFF, -1, -1);
      check("div_min_lo_const", lo, 32'h80000000);
      check("div_min_hi_const", hi, 32'd0);
      do_op("div_zero", 2'b10, 32'd1234, 32'd0, -1, -1);
      check("div_zero_lo_kept", lo, 32'h80000000);

      // Annul after ten iterations
      start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      check("annul_busy_before", busy, 1'b1);
      repeat (9) @(negedge clk);
      annul = 1'b1;
      @(negedge clk);
      annul = 1'b0;
      check("annul_busy_after", busy, 1'b0);
      watch_no_done("annul", 40);
      check("annul_hi_kept", hi, m_hi);
      check("annul_lo_kept", lo, m_lo);
      do_op("after_annul", 2'b11, 32'd100, 32'd7, -1, -1);

      // annul together with start: start is dropped
      start = 1'b1; annul = 1'b1; op = 2'b00; a = 32'd5; b = 32'd6;
      @(negedge clk);
      start = 1'b0; annul = 1'b0;
      check("annul_start_busy", busy, 1'b0);
      watch_no_done("annul_start", 4);

      // Direct write into HI mid-divide, then on the commit edge
      do_op("hiwr_mid", 2'b10, 32'hFFFF0001, 32'd77, 5, -1);
      do_op("hiwr_commit", 2'b10, 32'd123456, 32'hFFFFFFF3, 32, -1);

      // Direct LO write while idle leaves HI alone
      lo_we = 1'b1; wdata = 32'hCAFEF00D;
      @(negedge clk);
      lo_we = 1'b0;
      m_lo = 32'hCAFEF00D;
      check("lowr_lo", lo, m_lo);
      check("lowr_hi", hi, m_hi);

      // start while busy is ignored
      do_op("busy_start", 2'b11, 32'hDEADBEEF, 32'd1000, -1, 5);

      // Asynchronous reset in the middle of a multiply
      start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd7;
      @(posedge clk);
      #1 start = 1'b0;
      check("rstmid_busy_before", busy, 1'b1);
      #2 rst = 1'b0;
      #1;
      check("rstmid_busy", busy, 1'b0);
      check("rstmid_done", done, 1'b0);
      check("rstmid_dbz", dbz, 1'b0);
      check("rstmid_hi", hi, 32'd0);
      check("rstmid_lo", lo, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      m_hi = 32'd0;
      m_lo = 32'd0;
      do_op("after_rst", 2'b01, 32'h0001_0000, 32'h0001_0000, -1, -1);

      // Random operations against the reference model
      for (int i = 0; i < 30; i++) begin
         logic [1:0]  ro;
         logic [31:0] rx;
         logic [31:0] ry;
         int          sel;
         ro  = 2'($urandom_range(0, 3));
         rx  = $urandom;
         sel = $urandom_range(0, 7);
         case (sel)
            0:       ry = 32'd0;
            1:       ry = 32'($urandom_range(1, 5));
            2:       ry = 32'hFFFFFFFF;
            default: ry = $urandom;
         endcase
         do_op("rnd", ro, rx, ry, -1, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
